// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types, default sizes and helpers for the instruction-fetch stage.
//   fetch_state_t  - fetch FSM state (idle / run / done)
//   FETCH_ADDR_W   - default word-address width into inst_mem
//   FETCH_DATA_W   - default instruction width
//   FETCH_LAST_ADDR- default last fetchable word address
//   branch_target  - redirect target: br_pc + 1 + sign-extended imm, mod 2^FETCH_ADDR_W
package fetch_pkg;

  localparam int unsigned FETCH_ADDR_W    = 5;
  localparam int unsigned FETCH_DATA_W    = 32;
  localparam int unsigned FETCH_LAST_ADDR = 31;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } fetch_state_t;

  // Sign-extending and then truncating the immediate leaves exactly its low bits.
  function automatic logic [FETCH_ADDR_W-1:0] branch_target(
    input logic [FETCH_ADDR_W-1:0] br_pc,
    input logic [15:0]             br_imm
  );
    return br_pc + FETCH_ADDR_W'(1) + br_imm[FETCH_ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// fetch_next_pc: combinational next-PC select for the fetch stage.
//   pc_i        - current PC register
//   advance_i   - a capture happens this cycle (step past pc_i unless at the end)
//   redirect_i  - taken branch; wins over advance
//   br_pc_i     - word address of the branch instruction
//   br_imm_i    - signed word offset of the branch
//   pc_next_o   - hold / pc+1 / branch target
//   at_last_o   - pc_i is the last fetchable address
module fetch_next_pc #(
  parameter int unsigned ADDR_W    = fetch_pkg::FETCH_ADDR_W,
  parameter int unsigned LAST_ADDR = fetch_pkg::FETCH_LAST_ADDR
) (
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              advance_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] br_pc_i,
  input  logic [15:0]       br_imm_i,
  output logic [ADDR_W-1:0] pc_next_o,
  output logic              at_last_o
);
  import fetch_pkg::*;

  assign at_last_o = (pc_i == ADDR_W'(LAST_ADDR));

  always_comb begin
    pc_next_o = pc_i;
    if (redirect_i) begin
      pc_next_o = branch_target(br_pc_i, br_imm_i);
    end else if (advance_i && !at_last_o) begin
      // No wrap: the PC parks on the last address once it has been captured.
      pc_next_o = pc_i + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: stallable, flushable instruction-fetch stage in front of decode.
//   clk, reset_n     - clock, synchronous active-low reset
//   start            - leave idle (sampled only while idle)
//   imem_addr        - word address to inst_mem (the PC register)
//   imem_data        - instruction returned by inst_mem in the same cycle
//   if_instr, if_pc  - registered instruction and its word address
//   if_valid         - output register holds a live instruction
//   id_ready         - decode accepts; transfer = if_valid && id_ready
//   br_taken, br_pc, br_imm - branch redirect request and its operands
//   done             - last address has been fetched
//   fetch_count      - completed transfers, saturating at 255
module fetch_unit #(
  parameter int unsigned ADDR_W    = fetch_pkg::FETCH_ADDR_W,
  parameter int unsigned DATA_W    = fetch_pkg::FETCH_DATA_W,
  parameter int unsigned LAST_ADDR = fetch_pkg::FETCH_LAST_ADDR
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic              if_valid,
  input  logic              id_ready,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_pc,
  input  logic [15:0]       br_imm,
  output logic              done,
  output logic [7:0]        fetch_count
);
  import fetch_pkg::*;

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] if_instr_q, if_instr_d;
  logic [ADDR_W-1:0] if_pc_q, if_pc_d;
  logic              if_valid_q, if_valid_d;
  logic [7:0]        cnt_q, cnt_d;

  logic              redirect;
  logic              capture;
  logic              transfer;
  logic              at_last;
  logic [ADDR_W-1:0] pc_next;

  // Branches are ignored while idle; in run/done they flush and win over capture.
  assign redirect = br_taken && (state_q != StIdle);
  assign capture  = (state_q == StRun) && (!if_valid_q || id_ready) && !br_taken;
  assign transfer = if_valid_q && id_ready;

  fetch_next_pc #(
    .ADDR_W    (ADDR_W),
    .LAST_ADDR (LAST_ADDR)
  ) u_next_pc (
    .pc_i       (pc_q),
    .advance_i  (capture),
    .redirect_i (redirect),
    .br_pc_i    (br_pc),
    .br_imm_i   (br_imm),
    .pc_next_o  (pc_next),
    .at_last_o  (at_last)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_next;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    if_valid_d = if_valid_q;
    cnt_d      = cnt_q;

    // A transfer in a redirect cycle still counts.
    if (transfer && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (redirect) begin
          if_valid_d = 1'b0;
        end else if (capture) begin
          if_instr_d = imem_data;
          if_pc_d    = pc_q;
          if_valid_d = 1'b1;
          if (at_last) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (redirect) begin
          if_valid_d = 1'b0;
          state_d    = StRun;
        end else if (transfer) begin
          if_valid_d = 1'b0;
        end
      end
      default: begin
        state_d    = StIdle;
        if_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      pc_q       <= '0;
      if_instr_q <= '0;
      if_pc_q    <= '0;
      if_valid_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
      if_valid_q <= if_valid_d;
      cnt_q      <= cnt_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_instr    = if_instr_q;
  assign if_pc       = if_pc_q;
  assign if_valid    = if_valid_q;
  assign done        = (state_q == StDone);
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a combinational instruction memory model
// returning 0x1000_0000 + address.
module tb_fetch_unit;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [4:0]  imem_addr;
  logic [31:0] imem_data;
  logic [31:0] if_instr;
  logic [4:0]  if_pc;
  logic        if_valid;
  logic        id_ready;
  logic        br_taken;
  logic [4:0]  br_pc;
  logic [15:0] br_imm;
  logic        done;
  logic [7:0]  fetch_count;

  int n_vec = 0;
  int n_err = 0;

  fetch_unit dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_valid    (if_valid),
    .id_ready    (id_ready),
    .br_taken    (br_taken),
    .br_pc       (br_pc),
    .br_imm      (br_imm),
    .done        (done),
    .fetch_count (fetch_count)
  );

  assign imem_data = 32'h1000_0000 + 32'(imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    id_ready = 1'b1;
    br_taken = 1'b0;
    br_pc    = '0;
    br_imm   = '0;
    step();
    step();
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_instr", if_instr, 32'd0);
    chk("rst_pc", 32'(if_pc), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_count", 32'(fetch_count), 32'd0);

    // Idle: no fetch without start.
    reset_n = 1'b1;
    step();
    chk("idle_addr", 32'(imem_addr), 32'd0);
    chk("idle_valid", 32'(if_valid), 32'd0);

    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_valid", 32'(if_valid), 32'd0);

    // Streaming 0..31.
    for (int k = 0; k < 32; k++) begin
      step();
      chk("str_pc", 32'(if_pc), 32'(k));
      chk("str_instr", if_instr, 32'h1000_0000 + 32'(k));
      chk("str_valid", 32'(if_valid), 32'd1);
      chk("str_done", 32'(done), (k == 31) ? 32'd1 : 32'd0);
      chk("str_count", 32'(fetch_count), 32'(k));
      chk("str_addr", 32'(imem_addr), (k == 31) ? 32'd31 : 32'(k + 1));
    end
    step();
    chk("end_count", 32'(fetch_count), 32'd32);
    chk("end_valid", 32'(if_valid), 32'd0);
    chk("end_done", 32'(done), 32'd1);
    chk("end_addr", 32'(imem_addr), 32'd31);
    step();
    chk("done_nocap", 32'(if_valid), 32'd0);
    chk("done_count", 32'(fetch_count), 32'd32);

    // Backward branch from done: 1 + 1 - 4 = 30 mod 32.
    br_taken = 1'b1;
    br_pc    = 5'd1;
    br_imm   = 16'hFFFC;
    step();
    br_taken = 1'b0;
    chk("bwd_addr", 32'(imem_addr), 32'd30);
    chk("bwd_valid", 32'(if_valid), 32'd0);
    chk("bwd_done", 32'(done), 32'd0);
    step();
    chk("bwd_pc", 32'(if_pc), 32'd30);
    chk("bwd_instr", if_instr, 32'h1000_001E);
    step();
    chk("bwd_pc31", 32'(if_pc), 32'd31);
    chk("bwd_done2", 32'(done), 32'd1);
    chk("bwd_count", 32'(fetch_count), 32'd33);

    // Wrap-around branch 31 + 1 + 4 = 4; transfer of 31 still counts.
    br_taken = 1'b1;
    br_pc    = 5'd31;
    br_imm   = 16'h0004;
    step();
    br_taken = 1'b0;
    chk("wrap_addr", 32'(imem_addr), 32'd4);
    chk("wrap_valid", 32'(if_valid), 32'd0);
    chk("wrap_count", 32'(fetch_count), 32'd34);
    step();
    chk("bp_pc4", 32'(if_pc), 32'd4);
    chk("bp_addr5", 32'(imem_addr), 32'd5);

    // Back-pressure.
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_pc", 32'(if_pc), 32'd4);
      chk("bp_instr", if_instr, 32'h1000_0004);
      chk("bp_valid", 32'(if_valid), 32'd1);
      chk("bp_addr", 32'(imem_addr), 32'd5);
      chk("bp_count", 32'(fetch_count), 32'd34);
    end
    id_ready = 1'b1;
    step();
    chk("rel_pc5", 32'(if_pc), 32'd5);
    chk("rel_instr5", if_instr, 32'h1000_0005);
    chk("rel_count", 32'(fetch_count), 32'd35);
    step();
    chk("rel_pc6", 32'(if_pc), 32'd6);
    chk("rel_addr7", 32'(imem_addr), 32'd7);
    chk("rel_count2", 32'(fetch_count), 32'd36);

    // Forward branch 6 + 1 + 3 = 10.
    br_taken = 1'b1;
    br_pc    = 5'd6;
    br_imm   = 16'h0003;
    step();
    br_taken = 1'b0;
    chk("fwd_valid", 32'(if_valid), 32'd0);
    chk("fwd_addr", 32'(imem_addr), 32'd10);
    chk("fwd_count", 32'(fetch_count), 32'd37);
    step();
    chk("fwd_pc", 32'(if_pc), 32'd10);
    chk("fwd_instr", if_instr, 32'h1000_000A);
    chk("fwd_valid2", 32'(if_valid), 32'd1);
    step();
    step();
    chk("pre_rst_pc", 32'(if_pc), 32'd12);
    chk("pre_rst_count", 32'(fetch_count), 32'd39);

    // Reset together with a branch: reset wins.
    reset_n  = 1'b0;
    br_taken = 1'b1;
    br_pc    = 5'd0;
    br_imm   = 16'h0002;
    step();
    reset_n  = 1'b1;
    br_taken = 1'b0;
    chk("mrst_valid", 32'(if_valid), 32'd0);
    chk("mrst_instr", if_instr, 32'd0);
    chk("mrst_pc", 32'(if_pc), 32'd0);
    chk("mrst_addr", 32'(imem_addr), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk("mrst_count", 32'(fetch_count), 32'd0);

    // Idle ignores branches and does not fetch.
    br_taken = 1'b1;
    br_pc    = 5'd5;
    br_imm   = 16'h0000;
    step();
    br_taken = 1'b0;
    chk("idle_br_addr", 32'(imem_addr), 32'd0);
    step();
    chk("idle2_valid", 32'(if_valid), 32'd0);
    chk("idle2_addr", 32'(imem_addr), 32'd0);

    // Saturation: capture at 0, then transfer + redirect to 0 (31 + 1 + 0).
    start = 1'b1;
    step();
    start  = 1'b0;
    br_pc  = 5'd31;
    br_imm = 16'h0000;
    for (int i = 0; i < 300; i++) begin
      br_taken = 1'b0;
      step();
      if (i == 0) chk("sat_first_pc", 32'(if_pc), 32'd0);
      br_taken = 1'b1;
      step();
      if (i == 0)   chk("sat_c1", 32'(fetch_count), 32'd1);
      if (i == 253) chk("sat_c254", 32'(fetch_count), 32'd254);
      if (i == 254) chk("sat_c255", 32'(fetch_count), 32'd255);
      if (i == 255) chk("sat_hold", 32'(fetch_count), 32'd255);
    end
    br_taken = 1'b0;
    chk("sat_end", 32'(fetch_count), 32'd255);
    chk("sat_addr", 32'(imem_addr), 32'd0);
    chk("sat_valid", 32'(if_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
